dma_dim2_arb: RTL

Round-robin job scheduler that shares one 2-D address generator (dma_dim2) between NREQ requesters.
- Accepts per-requester 2-D descriptors and grants one requester at a time.
- Drives the generator's start handshake and monitors its output beat stream.
- Pulses a per-requester done when the job's final beat is accepted.
- Exactly one job is in flight; the next grant waits for completion.

---
 rtl/dma_dim2_arb.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dma_dim2_arb.sv
// +--------------------------------------------------------------------------+
// | dma_dim2_arb: round-robin scheduler sharing one dma_dim2 generator.       |
// | Optional beat counter: define DMA_DIM2_ARB_BEATCNT_EN.                    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module dma_dim2_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 14,
  parameter int IFW  = 4,
  parameter int SZW0 = 7,
  parameter int STW0 = 2,
  parameter int SZW1 = 5,
  parameter int STW1 = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_base,
  input  logic [NREQ*SZW0-1:0] req_dim0_size,
  input  logic [NREQ*STW0-1:0] req_dim0_step,
  input  logic [NREQ*SZW1-1:0] req_dim1_size,
  input  logic [NREQ*STW1-1:0] req_dim1_step,
  input  logic [NREQ*IFW-1:0]  req_info,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [AW-1:0]        base,
  output logic [SZW0-1:0]      dim0_size,
  output logic [STW0-1:0]      dim0_step,
  output logic [SZW1-1:0]      dim1_size,
  output logic [STW1-1:0]      dim1_step,
  output logic [IFW-1:0]       m_info,
  output logic                 start_valid,
  input  logic                 start_ready,
  input  logic                 s_valid,
  input  logic                 s_ready,
  input  logic                 s_last
`ifdef DMA_DIM2_ARB_BEATCNT_EN
  ,
  output logic [15:0]          job_beats,
  output logic                 beat_ovf
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [2:0]      r_ptr;
  logic [2:0]      w_win;
  logic [2:0]      w_ptr_nxt;
  logic [3:0]      w_sum;
  logic [NREQ-1:0] r_done;
  logic            w_any;
  logic            w_grant;
  logic            w_final;

  assign w_any   = |req_valid;
  assign w_grant = (r_state == S_IDLE) && w_any;
  assign w_final = (r_state == S_RUN) && s_valid && s_ready && s_last;
  assign done    = r_done;

  // Scan offsets from the highest down so the lowest offset from r_ptr wins.
  always_comb begin
    w_win = 3'd0;
    w_sum = 4'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + 4'(k);
      if (w_sum >= 4'(NREQ)) w_sum = w_sum - 4'(NREQ);
      if (req_valid[w_sum[IW-1:0]]) w_win = w_sum[2:0];
    end
  end

  assign w_ptr_nxt = (w_win == 3'(NREQ - 1)) ? 3'd0 : w_win + 3'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any)       w_next = S_ISSUE;
      S_ISSUE: if (start_ready) w_next = S_RUN;
      S_RUN:   if (w_final)     w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_win[IW-1:0]] = 1'b1;
    start_valid = (r_state == S_ISSUE);
    busy        = (r_state != S_IDLE);
  end

  // Descriptor registers hold after completion until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= 3'd0;
      grant_id  <= 3'd0;
      base      <= '0;
      dim0_size <= '0;
      dim0_step <= '0;
      dim1_size <= '0;
      dim1_step <= '0;
      m_info    <= '0;
      r_done    <= '0;
    end else begin
      r_done <= '0;
      if (w_grant) begin
        r_ptr     <= w_ptr_nxt;
        grant_id  <= w_win;
        base      <= req_base[int'(w_win)*AW +: AW];
        dim0_size <= req_dim0_size[int'(w_win)*SZW0 +: SZW0];
        dim0_step <= req_dim0_step[int'(w_win)*STW0 +: STW0];
        dim1_size <= req_dim1_size[int'(w_win)*SZW1 +: SZW1];
        dim1_step <= req_dim1_step[int'(w_win)*STW1 +: STW1];
        m_info    <= req_info[int'(w_win)*IFW +: IFW];
      end
      if (w_final) r_done[grant_id[IW-1:0]] <= 1'b1;
    end
  end

`ifdef DMA_DIM2_ARB_BEATCNT_EN
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_inc;
  logic        r_ovf;
  logic        w_sat;

  assign w_sat     = &r_cnt;
  assign w_cnt_inc = w_sat ? r_cnt : r_cnt + 16'd1;

  // Overflow is tracked per job and published together with job_beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 16'd0;
      r_ovf     <= 1'b0;
      job_beats <= 16'd0;
      beat_ovf  <= 1'b0;
    end else if (w_grant) begin
      r_cnt <= 16'd0;
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && s_valid && s_ready) begin
      r_cnt <= w_cnt_inc;
      r_ovf <= r_ovf | w_sat;
      if (s_last) begin
        job_beats <= w_cnt_inc;
        beat_ovf  <= r_ovf | w_sat;
      end
    end
  end
`endif

endmodule

`default_nettype wire
